// File: rtl/matrix_alu_seq.sv
// Sequential DIM x DIM signed matrix ALU: latches operands on start, writes one result element per step.
// Define MATRIX_MUL_EN to build the multiply (MAC) datapath; without it opcode 011 reports error.
module matrix_alu_seq #(
   parameter int DATA_W = 8,
   parameter int DIM    = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [2:0]                opcode,
   input  logic [DIM*DIM*DATA_W-1:0] A_flat,
   input  logic [DIM*DIM*DATA_W-1:0] B_flat,
   input  logic [DATA_W-1:0]         f,
   output logic [DIM*DIM*DATA_W-1:0] C_flat,
   output logic                      overflow_flag,
   output logic                      error,
   output logic                      busy,
   output logic                      done
);
   localparam int TOT = DIM*DIM*DATA_W;
   localparam int TW  = $clog2(TOT);
   localparam int CW  = $clog2(DIM);
   localparam int AW  = 2*DATA_W + CW;
   localparam logic signed [AW-1:0] MAX_V = AW'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
   localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_OPP = 3'b100;
   localparam logic [2:0] OP_TRN = 3'b101;
   localparam logic [2:0] OP_SCL = 3'b110;
`ifdef MATRIX_MUL_EN
   localparam logic [2:0] OP_MUL = 3'b011;
`endif

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;

   logic [TOT-1:0]    a_q, b_q, c_q;
   logic [DATA_W-1:0] f_q;
   logic [2:0]        op_q;
   logic              ovf_q, err_q, done_q;
   logic [CW-1:0]     row, col;
`ifdef MATRIX_MUL_EN
   logic [CW-1:0]     k;
   logic [AW-1:0]     acc;
`endif

   logic                     op_valid, elem_wr, last_el, ovf_el;
   int                       idx_c, idx_t, idx_a, idx_b;
   logic [TW-1:0]            pos_c, pos_t, pos_a, pos_b;
   logic signed [DATA_W-1:0] a_e, b_e, t_e, f_e;
   logic signed [AW-1:0]     a_x, b_x, t_x, f_x, full;

   always_comb begin
      op_valid = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB, OP_OPP, OP_TRN, OP_SCL: op_valid = 1'b1;
`ifdef MATRIX_MUL_EN
         OP_MUL: op_valid = 1'b1;
`endif
         default: op_valid = 1'b0;
      endcase
   end

   // Operand element selection; multiply walks A along the row and B down the column with k.
   always_comb begin
      idx_c = int'(row) * DIM + int'(col);
      idx_t = int'(col) * DIM + int'(row);
`ifdef MATRIX_MUL_EN
      idx_a = (op_q == OP_MUL) ? int'(row) * DIM + int'(k) : idx_c;
      idx_b = (op_q == OP_MUL) ? int'(k) * DIM + int'(col) : idx_c;
`else
      idx_a = idx_c;
      idx_b = idx_c;
`endif
      pos_c = TW'(idx_c * DATA_W);
      pos_t = TW'(idx_t * DATA_W);
      pos_a = TW'(idx_a * DATA_W);
      pos_b = TW'(idx_b * DATA_W);
      a_e = a_q[pos_a +: DATA_W];
      b_e = b_q[pos_b +: DATA_W];
      t_e = a_q[pos_t +: DATA_W];
      f_e = f_q;
      a_x = AW'(a_e);
      b_x = AW'(b_e);
      t_x = AW'(t_e);
      f_x = AW'(f_e);
   end

   // Full-precision element value; only the low DATA_W bits are stored.
   always_comb begin
      full = '0;
      case (op_q)
         OP_ADD: full = a_x + b_x;
         OP_SUB: full = a_x - b_x;
         OP_OPP: full = -a_x;
         OP_TRN: full = t_x;
         OP_SCL: full = a_x * f_x;
`ifdef MATRIX_MUL_EN
         OP_MUL: full = ((k == '0) ? '0 : acc) + a_x * b_x;
`endif
         default: full = '0;
      endcase
      ovf_el  = (full > MAX_V) || (full < MIN_V);
      last_el = (row == CW'(DIM-1)) && (col == CW'(DIM-1));
`ifdef MATRIX_MUL_EN
      elem_wr = (state == RUN) && ((op_q != OP_MUL) || (k == CW'(DIM-1)));
`else
      elem_wr = (state == RUN);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      case (state)
         IDLE: if (start) state_nx = op_valid ? RUN : DONE;
         RUN: begin
            busy = 1'b1;
            if (elem_wr && last_el) state_nx = DONE;
         end
         DONE: begin
            busy = 1'b1;
            if (done_q) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= '0;
         f_q    <= '0;
         op_q   <= '0;
         ovf_q  <= 1'b0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
         row    <= '0;
         col    <= '0;
`ifdef MATRIX_MUL_EN
         k      <= '0;
         acc    <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (start) begin
               a_q   <= A_flat;
               b_q   <= B_flat;
               f_q   <= f;
               op_q  <= opcode;
               c_q   <= '0;
               ovf_q <= 1'b0;
               err_q <= ~op_valid;
               row   <= '0;
               col   <= '0;
`ifdef MATRIX_MUL_EN
               k     <= '0;
`endif
            end
            RUN: begin
`ifdef MATRIX_MUL_EN
               if (op_q == OP_MUL) begin
                  acc <= full;
                  k   <= (k == CW'(DIM-1)) ? '0 : k + 1'b1;
               end
`endif
               if (elem_wr) begin
                  c_q[pos_c +: DATA_W] <= full[DATA_W-1:0];
                  if (ovf_el) ovf_q <= 1'b1;
                  if (col == CW'(DIM-1)) begin
                     col <= '0;
                     row <= row + 1'b1;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            // DONE lasts two cycles so the pulse lands one cycle after the last write.
            DONE: done_q <= ~done_q;
            default: ;
         endcase
      end
   end

   assign C_flat        = c_q;
   assign overflow_flag = ovf_q;
   assign error         = err_q;
   assign done          = done_q;

endmodule
